// File: rtl/app_core_mfb_meta_joiner.sv
// app_core_mfb_meta_joiner
// Attaches each per-packet header (MVB, one item per word) to the SOF word of
// the matching packet on a single-region MFB stream. The header leaves as
// TX_MFB_META. The header length field is checked against the counted packet
// length, and every mismatch is reported.
//
// Ports
//   CLK, RESET          clock, synchronous active-high reset
//   RX_MVB_*            header input (DATA, VLD, SRC_RDY, DST_RDY)
//   RX_MFB_*            packet data input (DATA, SOF, EOF, SOF_POS, EOF_POS,
//                       SRC_RDY, DST_RDY)
//   TX_MFB_*            packet data output with META (header at SOF, else 0)
//   ERR_LEN             one-cycle pulse with the EOF word of a mismatched packet
//   ERR_CNT             wrapping count of length mismatches
module app_core_mfb_meta_joiner #(
  parameter int unsigned REGION_SIZE    = 8,
  parameter int unsigned BLOCK_SIZE     = 8,
  parameter int unsigned ITEM_WIDTH     = 8,
  parameter int unsigned META_WIDTH     = 64,
  parameter int unsigned LEN_WIDTH      = 14,
  parameter int unsigned HDR_FIFO_DEPTH = 16
) (
  input  logic                                       CLK,
  input  logic                                       RESET,
  input  logic [META_WIDTH-1:0]                      RX_MVB_DATA,
  input  logic                                       RX_MVB_VLD,
  input  logic                                       RX_MVB_SRC_RDY,
  output logic                                       RX_MVB_DST_RDY,
  input  logic [REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH-1:0] RX_MFB_DATA,
  input  logic                                       RX_MFB_SOF,
  input  logic                                       RX_MFB_EOF,
  input  logic [$clog2(REGION_SIZE)-1:0]             RX_MFB_SOF_POS,
  input  logic [$clog2(REGION_SIZE*BLOCK_SIZE)-1:0]  RX_MFB_EOF_POS,
  input  logic                                       RX_MFB_SRC_RDY,
  output logic                                       RX_MFB_DST_RDY,
  output logic [REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH-1:0] TX_MFB_DATA,
  output logic                                       TX_MFB_SOF,
  output logic                                       TX_MFB_EOF,
  output logic [$clog2(REGION_SIZE)-1:0]             TX_MFB_SOF_POS,
  output logic [$clog2(REGION_SIZE*BLOCK_SIZE)-1:0]  TX_MFB_EOF_POS,
  output logic [META_WIDTH-1:0]                      TX_MFB_META,
  output logic                                       TX_MFB_SRC_RDY,
  input  logic                                       TX_MFB_DST_RDY,
  output logic                                       ERR_LEN,
  output logic [31:0]                                ERR_CNT
);

  localparam int unsigned W  = REGION_SIZE * BLOCK_SIZE;
  localparam int unsigned AW = $clog2(HDR_FIFO_DEPTH);
  localparam int unsigned CW = LEN_WIDTH + 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(HDR_FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  // ---------------------------------------------------------------- header FIFO
  logic [META_WIDTH-1:0] r_mem [HDR_FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_acc;
  logic [META_WIDTH-1:0] w_hdr;
  logic [LEN_WIDTH-1:0]  w_hdr_len;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  // Full refuses a push even when a pop happens in the same cycle.
  assign w_push    = RX_MVB_SRC_RDY & RX_MVB_VLD & ~w_full;
  assign w_pop     = w_acc & RX_MFB_SOF;
  assign w_hdr     = r_mem[r_rd_ptr];
  assign w_hdr_len = w_hdr[LEN_WIDTH-1:0];

  assign RX_MVB_DST_RDY = ~w_full;

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= RX_MVB_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------- MFB accept
  logic r_tx_vld;
  logic w_out_free;

  assign w_out_free     = ~r_tx_vld | TX_MFB_DST_RDY;
  // A SOF word waits until its header is in the FIFO.
  assign RX_MFB_DST_RDY = w_out_free & (~RX_MFB_SOF | ~w_empty);
  assign w_acc          = RX_MFB_SRC_RDY & RX_MFB_DST_RDY;

  // ------------------------------------------------------------ length check
  logic                 r_in_pkt;
  logic [CW-1:0]        r_cnt;
  logic [LEN_WIDTH-1:0] r_exp;

  logic                 w_in_pkt_nxt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [LEN_WIDTH-1:0] w_exp_nxt;
  logic                 w_chk;
  logic [CW-1:0]        w_final;
  logic [LEN_WIDTH-1:0] w_chk_exp;
  logic                 w_mismatch;
  logic [32:0]          w_sof_off;
  logic [32:0]          w_eof_items;

  function automatic logic [CW-1:0] sat(input logic [32:0] v);
    return (v > 33'(CNT_MAX)) ? CNT_MAX : v[CW-1:0];
  endfunction

  assign w_sof_off   = 33'(RX_MFB_SOF_POS) * 33'(BLOCK_SIZE);
  assign w_eof_items = 33'(RX_MFB_EOF_POS) + 33'd1;

  // EOF of the running packet is closed before a SOF in the same word opens
  // the next one, so an EOF-then-SOF word checks the old header and latches
  // the new one in one step.
  always_comb begin
    w_in_pkt_nxt = r_in_pkt;
    w_cnt_nxt    = r_cnt;
    w_exp_nxt    = r_exp;
    w_chk        = 1'b0;
    w_final      = '0;
    w_chk_exp    = r_exp;
    if (r_in_pkt) begin
      if (RX_MFB_EOF) begin
        w_chk        = 1'b1;
        w_final      = sat(33'(r_cnt) + w_eof_items);
        w_chk_exp    = r_exp;
        w_in_pkt_nxt = 1'b0;
        w_cnt_nxt    = '0;
      end else if (!RX_MFB_SOF) begin
        w_cnt_nxt = sat(33'(r_cnt) + 33'(W));
      end
      if (RX_MFB_SOF) begin
        w_in_pkt_nxt = 1'b1;
        w_cnt_nxt    = sat(33'(W) - w_sof_off);
        w_exp_nxt    = w_hdr_len;
      end
    end else if (RX_MFB_SOF) begin
      if (RX_MFB_EOF && (w_sof_off <= 33'(RX_MFB_EOF_POS))) begin
        w_chk     = 1'b1;
        w_final   = sat(w_eof_items - w_sof_off);
        w_chk_exp = w_hdr_len;
      end else begin
        w_in_pkt_nxt = 1'b1;
        w_cnt_nxt    = sat(33'(W) - w_sof_off);
        w_exp_nxt    = w_hdr_len;
      end
    end
  end

  assign w_mismatch = w_chk & (w_final != {1'b0, w_chk_exp});

  // ---------------------------------------------------------- output register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_tx_vld       <= 1'b0;
      TX_MFB_DATA    <= '0;
      TX_MFB_SOF     <= 1'b0;
      TX_MFB_EOF     <= 1'b0;
      TX_MFB_SOF_POS <= '0;
      TX_MFB_EOF_POS <= '0;
      TX_MFB_META    <= '0;
      r_in_pkt       <= 1'b0;
      r_cnt          <= '0;
      r_exp          <= '0;
      ERR_LEN        <= 1'b0;
      ERR_CNT        <= '0;
    end else begin
      ERR_LEN <= 1'b0;
      if (w_acc) begin
        r_tx_vld       <= 1'b1;
        TX_MFB_DATA    <= RX_MFB_DATA;
        TX_MFB_SOF     <= RX_MFB_SOF;
        TX_MFB_EOF     <= RX_MFB_EOF;
        TX_MFB_SOF_POS <= RX_MFB_SOF_POS;
        TX_MFB_EOF_POS <= RX_MFB_EOF_POS;
        TX_MFB_META    <= RX_MFB_SOF ? w_hdr : '0;
        r_in_pkt       <= w_in_pkt_nxt;
        r_cnt          <= w_cnt_nxt;
        r_exp          <= w_exp_nxt;
        ERR_LEN        <= w_mismatch;
        if (w_mismatch) ERR_CNT <= ERR_CNT + 32'd1;
      end else if (TX_MFB_DST_RDY) begin
        r_tx_vld <= 1'b0;
      end
    end
  end

  assign TX_MFB_SRC_RDY = r_tx_vld;

endmodule

// File: tb/tb_app_core_mfb_meta_joiner.sv
// Bench for app_core_mfb_meta_joiner: directed scenarios followed by a random
// packet stream, all compared each cycle against a packet-level reference
// model (header queue, absolute item positions for packet length).
module tb_app_core_mfb_meta_joiner;

  localparam int RS = 8, BS = 8, W = 64, MW = 64, LW = 14, DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [MW-1:0]  mvb_data;
  logic           mvb_vld, mvb_src, mvb_dst;
  logic [W*8-1:0] rx_data, tx_data;
  logic           rx_sof, rx_eof, rx_src, rx_dst;
  logic [2:0]     rx_sp, tx_sp;
  logic [5:0]     rx_ep, tx_ep;
  logic           tx_sof, tx_eof, tx_src, tx_dst;
  logic [MW-1:0]  tx_meta;
  logic           err_len;
  logic [31:0]    err_cnt;

  always #5 clk = ~clk;

  app_core_mfb_meta_joiner #(
    .REGION_SIZE(RS), .BLOCK_SIZE(BS), .ITEM_WIDTH(8),
    .META_WIDTH(MW), .LEN_WIDTH(LW), .HDR_FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(clk), .RESET(rst),
    .RX_MVB_DATA(mvb_data), .RX_MVB_VLD(mvb_vld),
    .RX_MVB_SRC_RDY(mvb_src), .RX_MVB_DST_RDY(mvb_dst),
    .RX_MFB_DATA(rx_data), .RX_MFB_SOF(rx_sof), .RX_MFB_EOF(rx_eof),
    .RX_MFB_SOF_POS(rx_sp), .RX_MFB_EOF_POS(rx_ep),
    .RX_MFB_SRC_RDY(rx_src), .RX_MFB_DST_RDY(rx_dst),
    .TX_MFB_DATA(tx_data), .TX_MFB_SOF(tx_sof), .TX_MFB_EOF(tx_eof),
    .TX_MFB_SOF_POS(tx_sp), .TX_MFB_EOF_POS(tx_ep), .TX_MFB_META(tx_meta),
    .TX_MFB_SRC_RDY(tx_src), .TX_MFB_DST_RDY(tx_dst),
    .ERR_LEN(err_len), .ERR_CNT(err_cnt)
  );

  // ------------------------------------------------------------ reference model
  logic [MW-1:0]  hq[$];
  bit             m_tx_vld, m_sof, m_eof, m_err, m_in_pkt;
  logic [W*8-1:0] m_data;
  logic [2:0]     m_sp;
  logic [5:0]     m_ep;
  logic [MW-1:0]  m_meta;
  logic [31:0]    m_errcnt;
  longint         m_wcnt, m_start;
  longint         m_exp;
  bit             last_acc, last_push;
  int             n_checks = 0, n_err = 0;

  typedef struct { bit s; bit e; int sp; int ep; } word_t;
  word_t     wq[$];
  logic [MW-1:0] hp[$];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W*8-1:0] rnd_data();
    logic [W*8-1:0] r;
    for (int i = 0; i < W*8/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [MW-1:0] mkhdr(input int len);
    logic [MW-1:0] h;
    h = {$urandom, $urandom};
    h[LW-1:0] = LW'(len);
    return h;
  endfunction

  // Packet length mismatch judged from absolute item positions in the stream.
  function automatic bit len_bad(input longint len, input longint exp);
    longint s;
    s = (len > 32767) ? 32767 : len;
    return s != exp;
  endfunction

  task automatic model_reset();
    hq.delete();
    m_tx_vld = 0; m_sof = 0; m_eof = 0; m_err = 0; m_in_pkt = 0;
    m_data = '0; m_sp = '0; m_ep = '0; m_meta = '0; m_errcnt = '0;
  endtask

  task automatic cycle();
    bit exp_mvb_rdy, exp_mfb_rdy, acc, push, was_in;
    logic [MW-1:0] hdr;
    longint off, end_pos;
    #1;
    exp_mvb_rdy = hq.size() < DEPTH;
    exp_mfb_rdy = (!m_tx_vld || tx_dst) && (!rx_sof || hq.size() != 0);
    if (!rst) begin
      chk("mvb_dst_rdy", mvb_dst, exp_mvb_rdy);
      chk("mfb_dst_rdy", rx_dst, exp_mfb_rdy);
    end
    acc  = !rst && rx_src && exp_mfb_rdy;
    push = !rst && mvb_src && mvb_vld && exp_mvb_rdy;
    last_acc = acc; last_push = push;
    if (rst) begin
      model_reset();
    end else begin
      m_err = 0;
      if (acc) begin
        hdr = '0;
        if (rx_sof) hdr = hq.pop_front();
        was_in  = m_in_pkt;
        off     = longint'(rx_sp) * BS;
        end_pos = m_wcnt * W + longint'(rx_ep);
        if (was_in && rx_eof) begin
          m_err = len_bad(end_pos + 1 - m_start, m_exp);
          m_in_pkt = 0;
        end
        if (rx_sof) begin
          if (!was_in && rx_eof && off <= longint'(rx_ep)) begin
            m_err = len_bad(longint'(rx_ep) + 1 - off, longint'(hdr[LW-1:0]));
          end else begin
            m_in_pkt = 1;
            m_start  = m_wcnt * W + off;
            m_exp    = longint'(hdr[LW-1:0]);
          end
        end
        m_wcnt++;
        m_tx_vld = 1; m_data = rx_data; m_sof = rx_sof; m_eof = rx_eof;
        m_sp = rx_sp; m_ep = rx_ep; m_meta = hdr;
        if (m_err) m_errcnt++;
      end else if (tx_dst) begin
        m_tx_vld = 0;
      end
      if (push) hq.push_back(mvb_data);
    end
    @(posedge clk); #1;
    chk("tx_src_rdy", tx_src, m_tx_vld);
    chk("tx_sof", tx_sof, m_sof);
    chk("tx_eof", tx_eof, m_eof);
    chk("tx_sof_pos", tx_sp, m_sp);
    chk("tx_eof_pos", tx_ep, m_ep);
    chk("tx_data", tx_data, m_data);
    chk("tx_meta", tx_meta, m_meta);
    chk("err_len", err_len, m_err);
    chk("err_cnt", err_cnt, m_errcnt);
  endtask

  // ------------------------------------------------------------------ drivers
  task automatic idle_in();
    mvb_src = 0; mvb_vld = 0; mvb_data = '0;
    rx_src = 0; rx_sof = 0; rx_eof = 0; rx_sp = '0; rx_ep = '0; rx_data = '0;
  endtask

  task automatic set_word(input bit s, input bit e, input int sp, input int ep);
    rx_src = 1; rx_sof = s; rx_eof = e; rx_sp = 3'(sp); rx_ep = 6'(ep);
    rx_data = rnd_data();
  endtask

  task automatic send_word(input bit s, input bit e, input int sp, input int ep);
    set_word(s, e, sp, ep);
    last_acc = 0;
    for (int i = 0; i < 100 && !last_acc; i++) cycle();
    if (!last_acc) begin
      n_checks++; n_err++;
      $error("FAIL mfb_accept_timeout: observed=not accepted expected=accepted");
    end
    rx_src = 0;
  endtask

  task automatic push_hdr(input logic [MW-1:0] h);
    mvb_src = 1; mvb_vld = 1; mvb_data = h;
    last_push = 0;
    for (int i = 0; i < 100 && !last_push; i++) cycle();
    if (!last_push) begin
      n_checks++; n_err++;
      $error("FAIL mvb_push_timeout: observed=not accepted expected=accepted");
    end
    mvb_src = 0; mvb_vld = 0;
  endtask

  // ----------------------------------------------------------------- sequence
  initial begin
    logic [MW-1:0] h;
    word_t t;
    bit cur_valid;
    int sp, ep, nw, len, hlen, c;

    m_wcnt = 0; m_start = 0; m_exp = 0;
    model_reset();
    idle_in();
    tx_dst = 1;
    rst = 1;
    repeat (3) cycle();
    rst = 0;
    cycle();
    chk("reset_mvb_dst_rdy", mvb_dst, 1'b1);

    // Single-word packet, correct length 64.
    push_hdr(mkhdr(64));
    send_word(1, 1, 0, 63);
    chk("t1_sof_eof", {tx_sof, tx_eof}, 2'b11);
    repeat (2) cycle();

    // SOF word waits five cycles for its header.
    set_word(1, 1, 0, 63);
    repeat (5) cycle();
    h = mkhdr(64);
    mvb_src = 1; mvb_vld = 1; mvb_data = h;
    cycle();
    mvb_src = 0; mvb_vld = 0;
    cycle();
    rx_src = 0;
    chk("t2_meta", tx_meta, h);
    cycle();

    // Packet A (80) closed and packet B (96) opened in the same word.
    push_hdr(mkhdr(80));
    push_hdr(mkhdr(96));
    send_word(1, 0, 0, 0);
    send_word(1, 1, 4, 15);
    send_word(0, 1, 0, 63);
    cycle();
    chk("t3_err_cnt", err_cnt, 32'd0);

    // Header says 100, packet carries 128 items.
    push_hdr(mkhdr(100));
    send_word(1, 0, 0, 0);
    send_word(0, 1, 0, 63);
    chk("t4_err_len", err_len, 1'b1);
    chk("t4_err_cnt", err_cnt, 32'd1);
    repeat (2) cycle();

    // Fill the header FIFO with MFB stalled, then pop and push together.
    for (int i = 0; i < DEPTH; i++) push_hdr(mkhdr(64));
    chk("t5_full", mvb_dst, 1'b0);
    set_word(1, 0, 0, 0);
    mvb_src = 1; mvb_vld = 1; mvb_data = mkhdr(64);
    cycle();
    rx_src = 0;
    cycle();
    mvb_src = 0; mvb_vld = 0;
    cycle();

    // TX back-pressure for ten cycles, then reset mid-packet.
    tx_dst = 0;
    set_word(0, 0, 0, 0);
    repeat (11) cycle();
    tx_dst = 1;
    rst = 1;
    cycle();
    rst = 0;
    idle_in();
    cycle();
    chk("t6_reset_src_rdy", tx_src, 1'b0);
    chk("t6_reset_err_cnt", err_cnt, 32'd0);
    push_hdr(mkhdr(64));
    send_word(1, 1, 0, 63);
    cycle();
    chk("t6_clean_err_cnt", err_cnt, 32'd0);

    // Length counter saturation: 32768 items must not alias a header of 0.
    push_hdr(mkhdr(0));
    send_word(1, 0, 0, 0);
    for (int i = 0; i < 510; i++) send_word(0, 0, 0, 0);
    send_word(0, 1, 0, 63);
    chk("sat_err_len", err_len, 1'b1);
    chk("sat_err_cnt", err_cnt, 32'd1);
    cycle();

    // Random packet stream.
    for (int p = 0; p < 40; p++) begin
      sp = $urandom_range(0, 7);
      nw = $urandom_range(1, 3);
      ep = (nw == 1) ? $urandom_range(sp * 8, 63) : $urandom_range(0, 63);
      len = (nw - 1) * 64 + ep + 1 - sp * 8;
      hlen = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 300) : len;
      hp.push_back(mkhdr(hlen));
      if (nw >= 2 && wq.size() > 0 && wq[wq.size()-1].e && !wq[wq.size()-1].s &&
          sp * 8 > wq[wq.size()-1].ep && $urandom_range(0, 1) == 1) begin
        t = wq.pop_back();
        t.s = 1; t.sp = sp;
        wq.push_back(t);
      end else begin
        if ($urandom_range(0, 7) == 0) wq.push_back('{s: 0, e: 0, sp: 0, ep: 0});
        wq.push_back('{s: 1, e: (nw == 1), sp: sp, ep: (nw == 1) ? ep : 0});
      end
      for (int k = 0; k < nw - 2; k++) wq.push_back('{s: 0, e: 0, sp: 0, ep: 0});
      if (nw >= 2) wq.push_back('{s: 0, e: 1, sp: 0, ep: ep});
    end

    cur_valid = 0;
    c = 0;
    while (c < 20000 && (wq.size() > 0 || hp.size() > 0 || cur_valid)) begin
      if (hp.size() > 0 && $urandom_range(0, 3) != 0) begin
        mvb_src = 1; mvb_vld = 1; mvb_data = hp[0];
      end else if ($urandom_range(0, 7) == 0) begin
        mvb_src = 1; mvb_vld = 0; mvb_data = {$urandom, $urandom};
      end else begin
        mvb_src = 0; mvb_vld = 0;
      end
      if (!cur_valid && wq.size() > 0 && $urandom_range(0, 4) != 0) begin
        t = wq.pop_front();
        set_word(t.s, t.e, t.sp, t.ep);
        cur_valid = 1;
      end
      if (!cur_valid) rx_src = 0;
      tx_dst = ($urandom_range(0, 3) != 0);
      cycle();
      if (last_push) void'(hp.pop_front());
      if (last_acc) cur_valid = 0;
      c++;
    end
    if (wq.size() > 0 || hp.size() > 0 || cur_valid) begin
      n_checks++; n_err++;
      $error("FAIL random_stream_timeout: observed=stream incomplete expected=stream drained");
    end
    idle_in();
    tx_dst = 1;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/app_core_mfb_meta_joiner.md
# app_core_mfb_meta_joiner

Joins the per-packet header stream (MVB, one item per word) with the packet data stream (single-region MFB) and emits the MFB with each header attached as SOF-aligned metadata. Sits on the Ethernet TX path of the application core, directly upstream of the TX MFB port that carries headers as MFB metadata. It also checks the header length field against the counted packet length and reports mismatches.

## Interface
Parameters:
- REGION_SIZE, 8, blocks per MFB word (power of two)
- BLOCK_SIZE, 8, items per block (power of two)
- ITEM_WIDTH, 8, bits per item
- META_WIDTH, 64, header width; header[LEN_WIDTH-1:0] is packet length in items
- LEN_WIDTH, 14, length field width (LEN_WIDTH ≤ META_WIDTH)
- HDR_FIFO_DEPTH, 16, header FIFO depth (power of two, ≥ 2)

Ports (W = REGION_SIZE*BLOCK_SIZE):
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- RX_MVB_DATA  in  META_WIDTH  header
- RX_MVB_VLD  in  1  item valid
- RX_MVB_SRC_RDY  in  1  header word valid
- RX_MVB_DST_RDY  out  1  header accepted
- RX_MFB_DATA  in  W*ITEM_WIDTH  data
- RX_MFB_SOF, RX_MFB_EOF  in  1 each  start/end of packet in word
- RX_MFB_SOF_POS  in  log2(REGION_SIZE)  SOF block index
- RX_MFB_EOF_POS  in  log2(W)  EOF item index
- RX_MFB_SRC_RDY  in  1;  RX_MFB_DST_RDY  out  1
- TX_MFB_DATA, TX_MFB_SOF, TX_MFB_EOF, TX_MFB_SOF_POS, TX_MFB_EOF_POS  out  as RX
- TX_MFB_META  out  META_WIDTH  header of the packet starting in this word; valid when TX_MFB_SOF=1
- TX_MFB_SRC_RDY  out  1;  TX_MFB_DST_RDY  in  1
- ERR_LEN  out  1  one-cycle pulse on length mismatch
- ERR_CNT  out  32  mismatch count, wraps

## Operation
- Header FIFO: MVB item written when RX_MVB_SRC_RDY & RX_MVB_VLD & RX_MVB_DST_RDY. RX_MVB_SRC_RDY without VLD is consumed and dropped. RX_MVB_DST_RDY = not full. Full blocks a push even if a pop occurs in the same cycle. No bypass: a header written in cycle t is poppable from t+1.
- MFB word accept: RX_MFB_DST_RDY = (output register empty or TX_MFB_DST_RDY) and (RX_MFB_SOF=0 or FIFO not empty). A word with SOF pops exactly one header on accept. The header is placed on TX_MFB_META; it is otherwise don't-care and driven 0.
- Word types, with in_pkt state (set by SOF, cleared by EOF):
  - continuation (in_pkt, no SOF/EOF)
  - SOF only
  - EOF only
  - SOF+EOF of one packet (not in_pkt, SOF_POS*BLOCK_SIZE ≤ EOF_POS)
  - EOF then SOF (in_pkt; closes the old packet and opens a new one)
- Length counter cnt (LEN_WIDTH+1 bits, saturating at all-ones):
  - continuation adds W
  - SOF start loads W − SOF_POS*BLOCK_SIZE
  - EOF close adds EOF_POS+1
  - single-word packet = EOF_POS+1 − SOF_POS*BLOCK_SIZE
- Expected length is latched from header[LEN_WIDTH-1:0] at SOF. At EOF, a final count ≠ expected causes ERR_LEN to pulse and ERR_CNT to increment. Data is forwarded unchanged either way.
- Words with SRC_RDY but no SOF/EOF while not in_pkt are forwarded unchanged, uncounted and unchecked.

## Timing
- Reset values: TX_MFB_SRC_RDY=0, ERR_LEN=0, ERR_CNT=0, RX_MVB_DST_RDY=1 on the cycle after reset. All other TX outputs are 0. FIFO empty, in_pkt=0, cnt=0.
- RESET mid-packet discards the FIFO contents, the output register and any partial count. No error is reported for the aborted packet.
- Latency: 1 cycle from accepted RX MFB word to TX_MFB_SRC_RDY. The output register holds stable while TX_MFB_SRC_RDY & !TX_MFB_DST_RDY. Full throughput when the header FIFO is non-empty.
- ERR_LEN is asserted in the same cycle the EOF word appears on TX; ERR_CNT updates in that cycle.
- RX_MFB_DST_RDY is combinational from TX_MFB_DST_RDY and FIFO empty state. RX_MVB_DST_RDY is registered state only.

## Test plan
- REGION_SIZE=8, BLOCK_SIZE=8. Header len=64, 1-word packet SOF_POS=0 EOF_POS=63 -> TX SOF/EOF word one cycle later, META=header, ERR_CNT=0.
- MFB SOF word arrives 5 cycles before its header -> RX_MFB_DST_RDY=0 for those cycles. Word is accepted the cycle after the header is written and emitted with the correct META.
- Word with EOF_POS=15 closing packet A (len 80) and SOF_POS=4 opening packet B (len 96, ends EOF_POS=63 next word) -> two headers popped in order, no error.
- Header len=100, actual packet 128 items -> single ERR_LEN pulse on the EOF output cycle, ERR_CNT=1, data unchanged.
- 16 headers pushed, MFB stalled -> RX_MVB_DST_RDY=0 at 16; simultaneous pop+push at full still refuses the push.
- TX_MFB_DST_RDY held low 10 cycles -> TX outputs stable. RESET mid-packet -> all outputs at reset values, next packet checks cleanly.
